gshare_counter_table: RTL and testbench

Second stage of the branch predictor. Each cycle it takes the 6-bit hashed index produced by the pattern-history stage (pattern XOR PC) and looks up a table of 2-bit saturating counters, returning a registered taken/not-taken prediction. Every accepted lookup is queued in an in-order FIFO so that later branch resolutions can train the correct counter and flag mispredictions to the fetch/redirect logic.

---
 rtl/gshare_counter_table.sv | 117 +++++++++++
 tb/tb_gshare_counter_table.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gshare_counter_table.sv
// gshare counter table: 2-bit saturating counters indexed by the hashed
// pattern/PC index, with a registered prediction and an in-order FIFO of
// in-flight lookups that later resolutions use to train the counters.
module gshare_counter_table #(
  parameter int         INDEX_W  = 6,
  parameter int         DEPTH    = 4,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lookup_valid,
  input  logic [INDEX_W-1:0]         lookup_index,
  output logic                       lookup_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  output logic                       resolve_ready,
  output logic                       mispredict,
  output logic [7:0]                 mispredict_count,
  output logic [$clog2(DEPTH):0]     inflight
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               ENTRIES  = 1 << INDEX_W;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   OCC_ONE  = 1;
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);

  // Two-bit counter training step, saturating at both ends.
  function automatic logic [1:0] ctr_sat_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Statistics counter increment that sticks at its maximum.
  function automatic logic [7:0] count_sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [1:0]         ctr       [ENTRIES];
  logic [INDEX_W-1:0] fifo_idx  [DEPTH];
  logic               fifo_pred [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  logic [INDEX_W-1:0] pop_idx;
  logic               pop_pred;
  logic               lookup_pred;

  // Handshakes depend only on the registered occupancy; a full FIFO refuses
  // a lookup even when a pop happens in the same cycle.
  assign lookup_ready  = (inflight != OCC_FULL);
  assign resolve_ready = (inflight != '0);
  assign push          = lookup_valid && lookup_ready;
  assign pop           = resolve_valid && resolve_ready;
  assign pop_idx       = fifo_idx[rd_ptr];
  assign pop_pred      = fifo_pred[rd_ptr];
  // Lookup reads the pre-update counter; a same-cycle resolve is not bypassed.
  assign lookup_pred   = ctr[lookup_index][1];

  // Counter table: reset to CTR_INIT, trained by the popped entry's outcome.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (pop) begin
      ctr[pop_idx] <= ctr_sat_update(ctr[pop_idx], resolve_taken);
    end
  end

  // FIFO payload storage; contents are meaningless outside the occupied range.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]  <= lookup_index;
      fifo_pred[wr_ptr] <= lookup_pred;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      inflight <= inflight + OCC_ONE;
      else if (pop && !push) inflight <= inflight - OCC_ONE;
    end
  end

  // Registered prediction; pred_taken holds when no lookup is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= push;
      if (push) pred_taken <= lookup_pred;
    end
  end

  // Misprediction pulse and saturating statistic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredict       <= 1'b0;
      mispredict_count <= '0;
    end else begin
      mispredict <= pop && (resolve_taken != pop_pred);
      if (pop && (resolve_taken != pop_pred))
        mispredict_count <= count_sat_inc(mispredict_count);
    end
  end

endmodule

// File: tb/tb_gshare_counter_table.sv
// Bench for gshare_counter_table: a queue-based reference model predicts every
// response; a negedge monitor pops expectations and compares.
module tb_gshare_counter_table;

  localparam int DEPTH   = 4;
  localparam int INDEX_W = 6;
  localparam int ENTRIES = 1 << INDEX_W;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               lookup_valid = 1'b0;
  logic [INDEX_W-1:0] lookup_index = '0;
  logic               lookup_ready;
  logic               pred_valid;
  logic               pred_taken;
  logic               resolve_valid = 1'b0;
  logic               resolve_taken = 1'b0;
  logic               resolve_ready;
  logic               mispredict;
  logic [7:0]         mispredict_count;
  logic [2:0]         inflight;

  gshare_counter_table #(.INDEX_W(INDEX_W), .DEPTH(DEPTH), .CTR_INIT(2'b01)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
    .mispredict(mispredict), .mispredict_count(mispredict_count), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit pred; } ent_t;

  // Reference model state
  int   ctr_m [ENTRIES];
  ent_t mq[$];
  int   cnt_m;
  bit   exp_pred_q[$];
  bit   exp_mis_q[$];
  bit   mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) ctr_m[i] = 1;
    mq.delete();
    exp_pred_q.delete();
    exp_mis_q.delete();
    cnt_m = 0;
  endtask

  // Drive one cycle of stimulus and advance the model at the clock edge.
  task automatic cycle(input bit lv, input int li, input bit rv, input bit rt);
    bit   acc_l, acc_r, p;
    ent_t e;
    lookup_valid  = lv;
    lookup_index  = li[INDEX_W-1:0];
    resolve_valid = rv;
    resolve_taken = rt;
    @(posedge clk);
    acc_l = lv && (mq.size() < DEPTH);
    acc_r = rv && (mq.size() > 0);
    p = (ctr_m[li] >= 2);
    if (acc_r) begin
      e = mq.pop_front();
      if (rt) ctr_m[e.idx] = (ctr_m[e.idx] + 1 > 3) ? 3 : ctr_m[e.idx] + 1;
      else    ctr_m[e.idx] = (ctr_m[e.idx] - 1 < 0) ? 0 : ctr_m[e.idx] - 1;
      exp_mis_q.push_back(rt != e.pred);
      if (rt != e.pred && cnt_m < 255) cnt_m++;
    end
    if (acc_l) begin
      mq.push_back('{idx: li, pred: p});
      exp_pred_q.push_back(p);
    end
    #1;
    lookup_valid  = 1'b0;
    resolve_valid = 1'b0;
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (pred_valid) begin
        if (exp_pred_q.size() == 0) check("pred_valid_unexpected", 1, 0);
        else check("pred_taken", pred_taken, exp_pred_q.pop_front());
      end else if (exp_pred_q.size() != 0) begin
        check("pred_valid_missing", 0, 1);
        void'(exp_pred_q.pop_front());
      end
      if (exp_mis_q.size() != 0) check("mispredict", mispredict, exp_mis_q.pop_front());
      else check("mispredict_idle", mispredict, 0);
      check("mispredict_count", mispredict_count, cnt_m);
      check("inflight", inflight, mq.size());
      check("lookup_ready", lookup_ready, (mq.size() < DEPTH) ? 1 : 0);
      check("resolve_ready", resolve_ready, (mq.size() > 0) ? 1 : 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1;
    check("reset_inflight", inflight, 0);
    check("reset_pred_valid", pred_valid, 0);
    check("reset_pred_taken", pred_taken, 0);
    check("reset_mispredict", mispredict, 0);
    check("reset_count", mispredict_count, 0);
    check("reset_lookup_ready", lookup_ready, 1);
    check("reset_resolve_ready", resolve_ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Train index 5 taken: 01 -> 10 -> 11, then saturate, then step back to 10.
    for (int k = 0; k < 4; k++) begin
      cycle(1, 5, 0, 0);
      cycle(0, 0, 1, 1);
    end
    cycle(1, 5, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 5, 0, 0);
    cycle(0, 0, 1, 1);

    // Fill, refuse a fifth lookup, then pop while full with a lookup pending.
    for (int k = 0; k < 4; k++) cycle(1, 10 + k, 0, 0);
    cycle(1, 7, 0, 0);
    cycle(1, 8, 1, 0);
    cycle(1, 8, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, k[0]);

    // Resolve on an empty FIFO is ignored.
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);

    // Force 300 mispredicts to saturate the statistic.
    for (int k = 0; k < 300; k++) begin
      cycle(1, 20, 0, 0);
      cycle(0, 0, 1, !mq[0].pred);
    end

    // Randomized traffic with a small index range to provoke collisions.
    for (int k = 0; k < 600; k++)
      cycle($urandom_range(0, 1), $urandom_range(0, 7),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
    while (mq.size() > 0) cycle(0, 0, 1, $urandom_range(0, 1));

    // Bring counter 9 to 11, leave 3 entries in flight, then reset mid-cycle.
    cycle(1, 9, 0, 0);
    cycle(0, 0, 1, 1);
    cycle(1, 9, 0, 0);
    cycle(0, 0, 1, 1);
    for (int k = 0; k < 3; k++) cycle(1, 30 + k, 0, 0);
    @(negedge clk);
    mon_en = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_inflight", inflight, 0);
    check("async_reset_pred_valid", pred_valid, 0);
    check("async_reset_pred_taken", pred_taken, 0);
    check("async_reset_mispredict", mispredict, 0);
    check("async_reset_count", mispredict_count, 0);
    check("async_reset_resolve_ready", resolve_ready, 0);
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    cycle(1, 9, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("pred_queue_drained", exp_pred_q.size(), 0);
    check("mis_queue_drained", exp_mis_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
